// File: rtl/clb_cfg_loader.sv
// ---------------------------------------------------------------------------
// clb_cfg_loader
//   Serial configuration loader for a single CLB tile. It watches a bit-serial
//   config stream for a preamble, then shifts one CFG_W-bit frame into a
//   shadow register. The frame is followed by one bit that makes the total
//   count of ones even. Only a frame that passes this parity check is copied
//   into CFG, so CFG never shows a half-loaded frame.
//
//   Optional feature, macro CLB_CFG_READBACK_EN: serial readback of the
//   committed configuration, sent MSB first and followed by an even-parity bit.
//
// Ports
//   K          clock; all state changes on its rising edge
//   RST        synchronous, active-high reset
//   DIN        serial config data bit
//   DVALID     DIN is sampled only on cycles where this is 1
//   ABORT      discards any frame in progress and returns to IDLE
//   CFG        committed configuration (LUT mem, mux selects, DQ muxes, mode)
//   CFG_LOAD   one-cycle pulse on the cycle CFG changes
//   BUSY       high while a frame or its parity bit is being received
//   DONE       sticky; set on any successful commit
//   ERR        sticky; set on parity failure, cleared by the next good commit
//   RB_REQ     (readback only) request a serial dump of CFG
//   DOUT       (readback only) readback data, MSB first, then parity
//   DOUT_VALID (readback only) high for the CFG_W+1 readback cycles
// ---------------------------------------------------------------------------
module clb_cfg_loader #(
  parameter int               CFG_W     = 37,
  parameter int               PRE_W     = 8,
  parameter logic [PRE_W-1:0] PREAMBLE  = 8'hB2,
  parameter logic [CFG_W-1:0] RESET_CFG = 37'h0022C54038
) (
  input  logic             K,
  input  logic             RST,
  input  logic             DIN,
  input  logic             DVALID,
  input  logic             ABORT,
`ifdef CLB_CFG_READBACK_EN
  input  logic             RB_REQ,
  output logic             DOUT,
  output logic             DOUT_VALID,
`endif
  output logic [CFG_W-1:0] CFG,
  output logic             CFG_LOAD,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  localparam int               CNT_W    = $clog2(CFG_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CFG_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t           state;
  logic [PRE_W-1:0] hunt;
  logic [CNT_W-1:0] count;
  logic [CFG_W-1:0] shadow;
  logic             par_acc;
  logic [PRE_W-1:0] hunt_next;

  // Preamble hunting compares the value the hunt register is about to take.
  // A match is therefore recognised on the cycle of the last preamble bit,
  // and overlapping patterns are found naturally.
  assign hunt_next = {hunt[PRE_W-2:0], DIN};

  // Loader FSM. BUSY is registered alongside the state, so it is an exact
  // decode of LOAD/PAR. CFG is only written from the shadow register after a
  // good parity check. ABORT takes priority over every state action,
  // including the parity bit, and leaves CFG/DONE/ERR untouched.
  always_ff @(posedge K) begin
    if (RST) begin
      state    <= IDLE;
      hunt     <= '0;
      count    <= '0;
      shadow   <= '0;
      par_acc  <= 1'b0;
      CFG      <= RESET_CFG;
      CFG_LOAD <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      CFG_LOAD <= 1'b0;
      if (ABORT) begin
        state  <= IDLE;
        BUSY   <= 1'b0;
        hunt   <= '0;
        count  <= '0;
        shadow <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (DVALID) begin
              hunt <= hunt_next;
              if (hunt_next == PREAMBLE) begin
                state   <= LOAD;
                BUSY    <= 1'b1;
                count   <= '0;
                par_acc <= 1'b0;
              end
            end
          end
          LOAD: begin
            if (DVALID) begin
              shadow  <= {shadow[CFG_W-2:0], DIN};
              par_acc <= par_acc ^ DIN;
              count   <= count + 1'b1;
              if (count == LAST_BIT) begin
                state <= PAR;
              end
            end
          end
          PAR: begin
            if (DVALID) begin
              if ((par_acc ^ DIN) == 1'b0) begin
                CFG      <= shadow;
                CFG_LOAD <= 1'b1;
                DONE     <= 1'b1;
                ERR      <= 1'b0;
              end else begin
                ERR <= 1'b1;
              end
              state <= IDLE;
              BUSY  <= 1'b0;
              hunt  <= '0;
            end
          end
          default: begin
            state <= IDLE;
            BUSY  <= 1'b0;
            hunt  <= '0;
          end
        endcase
      end
    end
  end

`ifdef CLB_CFG_READBACK_EN
  logic [CFG_W:0]   rb_shift;
  logic [CNT_W-1:0] rb_count;
  logic             rb_active;

  // Readback takes a snapshot of CFG plus its even-parity bit and shifts it
  // out MSB first. The MSB is already on DOUT the cycle after the request.
  // rb_count tracks which of the CFG_W+1 bits is currently shown. The shift
  // register is cleared at the end, so DOUT returns to 0.
  always_ff @(posedge K) begin
    if (RST || ABORT) begin
      rb_shift  <= '0;
      rb_count  <= '0;
      rb_active <= 1'b0;
    end else if (rb_active) begin
      if (rb_count == CNT_W'(CFG_W)) begin
        rb_active <= 1'b0;
        rb_shift  <= '0;
        rb_count  <= '0;
      end else begin
        rb_shift <= {rb_shift[CFG_W-1:0], 1'b0};
        rb_count <= rb_count + 1'b1;
      end
    end else if (RB_REQ && (state == IDLE)) begin
      rb_shift  <= {CFG, ^CFG};
      rb_count  <= '0;
      rb_active <= 1'b1;
    end
  end

  assign DOUT       = rb_shift[CFG_W];
  assign DOUT_VALID = rb_active;
`endif

endmodule

// File: doc/clb_cfg_loader.md
Name: clb_cfg_loader

Overview:
- Serial configuration loader/controller for a single CLB tile.
- Hunts a preamble on a bit-serial config stream and shifts in one 37-bit configuration frame.
- Checks even parity, then atomically commits the frame to the parallel config register that drives the CLB's LUT memory, mux selects, DQ muxes and flop/latch mode.
- Sits between the chip-level config shifter and each CLB instance.

Parameters:
CFG_W, 37, configuration frame width in bits
PRE_W, 8, preamble width in bits
PREAMBLE, 8'hB2, preamble pattern that precedes each frame
RESET_CFG, 37'h0022C54038, config value after reset

Ports:
K  input  1  clock; all state changes on its rising edge
RST  input  1  synchronous, active-high reset
DIN  input  1  serial config data bit
DVALID  input  1  DIN is sampled only on cycles where this is 1
ABORT  input  1  discards any frame in progress and returns to IDLE
CFG  output  CFG_W  committed configuration
CFG_LOAD  output  1  one-cycle pulse on the cycle CFG changes
BUSY  output  1  high in LOAD and PAR
DONE  output  1  sticky; set on any successful commit
ERR  output  1  sticky; set on parity failure, cleared by the next successful commit

Behaviour:
- CFG field map, MSB to LSB:
  - [36:21] LUT mem[15:0]
  - [20:19] comboption
  - [18:17] mux2select; [16:15] mux3select; [14:13] mux4select; [12:11] mux5select; [10:9] mux6select
  - [8:3] o2m1_0, o2m2_0, o2m3_0, o2m1_1, o2m2_1, o2m3_1
  - [2:1] DQmux1, DQmux2
  - [0] floporlatch
- RESET_CFG decodes as:
  - mem = 16'h0116
  - mux2/3/4 selects = 2'b10, mux5/6 selects = 2'b00
  - comboption = 2'b00
  - o2m = 6'b000111
  - DQmux1/2 = 0, floporlatch = 0
- Reset values, RST=1 at a K edge:
  - CFG = RESET_CFG
  - CFG_LOAD = 0, BUSY = 0, DONE = 0, ERR = 0
  - state = IDLE, hunt register = 0, bit counter = 0, shadow register = 0
  - RST overrides every other input, including mid-frame.
- States: IDLE, LOAD, PAR.
- IDLE:
  - On each DVALID cycle, the PRE_W-bit hunt register shifts left with DIN entering the LSB.
  - If the post-shift value equals PREAMBLE, go to LOAD with counter = 0 and parity accumulator = 0.
  - Overlapping preambles are detected.
- LOAD:
  - Each DVALID cycle shifts DIN into the shadow register LSB (first bit ends up in CFG[36]), XORs DIN into the parity accumulator and increments the counter.
  - When the counter reaches CFG_W-1 and a valid bit arrives, go to PAR.
  - Cycles with DVALID=0 hold all state.
- PAR:
  - On the next DVALID cycle, evaluate accumulator XOR DIN.
  - Result 0: CFG <= shadow, CFG_LOAD = 1 for exactly the following cycle, DONE <= 1, ERR <= 0.
  - Result 1: ERR <= 1, CFG unchanged, no CFG_LOAD.
  - Either result: go to IDLE, clearing the hunt register, so the next frame needs 8 fresh preamble bits.
- Latency: CFG and CFG_LOAD update on the K edge after the parity bit is sampled, i.e. visible 1 cycle after the parity-bit cycle.
- BUSY = 1 exactly while the state is LOAD or PAR (registered state decode).
- ABORT:
  - In any state, next state is IDLE; hunt register, counter and shadow are cleared.
  - CFG, DONE and ERR are unchanged; the DIN bit of that cycle is discarded.
  - ABORT together with the parity bit: ABORT wins, no commit.
- The CFG output never shows a partially loaded frame.

Optional Feature:
- Macro: CLB_CFG_READBACK_EN.
- When defined, three extra ports exist:
  - RB_REQ (input, 1)
  - DOUT (output, 1)
  - DOUT_VALID (output, 1)
- Readback behaviour:
  - RB_REQ=1 in IDLE, with no readback active, snapshots CFG.
  - From the next cycle, DOUT emits CFG_W bits MSB first, one per K cycle, followed by one even-parity bit; DOUT_VALID = 1 for these 38 cycles, else 0.
  - RB_REQ during readback or outside IDLE is ignored.
  - A preamble arriving during readback still starts LOAD; the snapshot is unaffected.
  - RST and ABORT stop readback; DOUT and DOUT_VALID go to 0.
- When undefined: the ports are absent and there is no readback logic.

Test Plan:
- Reset then idle 10 cycles -> CFG=37'h0022C54038, BUSY=0, DONE=0, ERR=0, CFG_LOAD=0.
- Preamble 8'hB2 + frame 37'h1F0F0F0F0F + parity 1 (all DVALID=1) -> BUSY high 38 cycles, CFG=37'h1F0F0F0F0F 1 cycle after the parity bit, single CFG_LOAD pulse, DONE=1.
- Same frame with parity 0 -> ERR=1, CFG keeps its prior value, no CFG_LOAD; then a correct frame -> commit, ERR=0.
- Frame bits interleaved with random DVALID=0 gaps -> identical CFG to the gap-free case; bits presented while DVALID=0 are not captured.
- ABORT asserted at bit 20 of a frame, then the remaining bits sent without a new preamble -> no commit, BUSY=0 after ABORT, CFG unchanged.
- Stream 8'hB2 preceded by 1,0,1 (overlap test), and RST pulsed mid-LOAD -> preamble detected correctly; after RST, CFG=RESET_CFG and state is IDLE.
